// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with clock glitch filter, frame decoder,
// parity/framing/timeout error reporting and a first-word-fallthrough
// byte FIFO with a valid/ready handshake on the consumer side.
module ps2_rx_fifo #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          ps2_clk_async_i,
    input  logic                          ps2_data_async_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          parity_err_o,
    output logic                          frame_err_o,
    output logic                          overflow_o
);

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // Input synchronisers
    logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;

    // Glitch filter
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          filt_clk_q, filt_clk_d;
    logic          filt_dly_q;
    logic          fall;
    logic          bit_in;

    // Frame decoder
    state_t        state_q, state_d;
    byte_t         shift_q, shift_d;
    logic [2:0]    bits_q, bits_d;
    logic          par_q, par_d;
    logic          ok_q, ok_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          push;
    logic          perr_q, perr_d;
    logic          ferr_q, ferr_d;

    // FIFO
    byte_t         mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop, full, wr_en;

    // Two-flop synchronisers; pins idle high so reset to 1
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_async_i;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data_async_i;
            data_sync_q <= data_meta_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_cnt_d = '0;
        filt_clk_d = filt_clk_q;
        if (clk_sync_q != filt_clk_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                filt_clk_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall   = filt_dly_q & ~filt_clk_q;
    assign bit_in = data_sync_q;

    // Filter state and one-cycle-delayed copy used for edge detection
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            filt_cnt_q <= '0;
            filt_clk_q <= 1'b1;
            filt_dly_q <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_clk_q <= filt_clk_d;
            filt_dly_q <= filt_clk_q;
        end
    end

    // Frame decoder next state; a fall in the timeout cycle takes priority
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bits_d  = bits_q;
        par_d   = par_q;
        ok_d    = ok_q;
        timer_d = '0;
        push    = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        if (state_q != S_IDLE) begin
            timer_d = timer_q + 1'b1;
        end
        if (fall) begin
            timer_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (!bit_in) begin
                        state_d = S_DATA;
                        shift_d = '0;
                        bits_d  = '0;
                        par_d   = 1'b0;
                    end
                end
                S_DATA: begin
                    shift_d = {bit_in, shift_q[7:1]};
                    par_d   = par_q ^ bit_in;
                    bits_d  = bits_q + 1'b1;
                    if (bits_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    ok_d    = par_q ^ bit_in;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    if (bit_in) begin
                        push   = ok_q;
                        perr_d = ~ok_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && timer_q == TMO_LAST) begin
            state_d = S_IDLE;
            shift_d = '0;
            timer_d = '0;
            ferr_d  = 1'b1;
        end
    end

    // Frame decoder registers and registered error pulses
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            bits_q  <= '0;
            par_q   <= 1'b0;
            ok_q    <= 1'b0;
            timer_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bits_q  <= bits_d;
            par_q   <= par_d;
            ok_q    <= ok_d;
            timer_q <= timer_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    // FIFO bookkeeping; a pop frees the slot so push-while-full succeeds with a pop
    always_comb begin
        pop      = (count_q != '0) & ready_i;
        full     = (count_q == FULL_CNT);
        wr_en    = push & (~full | pop);
        ovf_d    = push & full & ~pop;
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents are only observed while occupancy is non-zero
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign valid_o      = (count_q != '0);
    assign data_o       = valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign count_o      = count_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: drives PS/2 frames on the raw pins and
// checks FIFO contents, handshake and error pulses with immediate assertions.
module tb_ps2_rx_fifo;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 10000;
    localparam int FIFO_DEPTH     = 8;
    localparam int HALF           = 16;

    logic       clk = 1'b0;
    logic       reset_ni = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic [3:0] count_o;
    logic       parity_err_o, frame_err_o, overflow_o;

    int n_assert = 0;
    int n_fail   = 0;
    int perr_cnt = 0;
    int ferr_cnt = 0;
    int ovf_cnt  = 0;
    int p0, f0, o0;

    ps2_rx_fifo #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FIFO_DEPTH    (FIFO_DEPTH)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_ni),
        .ps2_clk_async_i (ps2_clk),
        .ps2_data_async_i(ps2_data),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .ready_i         (ready),
        .count_o         (count_o),
        .parity_err_o    (parity_err_o),
        .frame_err_o     (frame_err_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk = ~clk;

    // Count one-cycle pulses, sampled just after the active edge
    always @(posedge clk) begin
        #1;
        if (parity_err_o) perr_cnt++;
        if (frame_err_o)  ferr_cnt++;
        if (overflow_o)   ovf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data set while clock high, then a low phase; optional
    // sub-filter-length glitches injected into both phases
    task automatic ps2_bit(input logic b, input bit g);
        ps2_data = b;
        if (g) begin
            wait_cyc(8);
            ps2_clk = 1'b0;
            wait_cyc(FILTER_LEN - 1);
            ps2_clk = 1'b1;
            wait_cyc(HALF - 8 - (FILTER_LEN - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b0;
        if (g) begin
            wait_cyc(8);
            ps2_clk = 1'b1;
            wait_cyc(FILTER_LEN - 1);
            ps2_clk = 1'b0;
            wait_cyc(HALF - 8 - (FILTER_LEN - 1));
        end else begin
            wait_cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par, input bit g);
        ps2_bit(1'b0, g);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], g);
        ps2_bit(par, g);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit g);
        send_head(d, par, g);
        ps2_bit(stop, g);
        ps2_data = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic pop_one();
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2 reset_ni = 1'b0;
        wait_cyc(5);
        chk("rst_data", data_o, 8'h00);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_count", count_o, 4'd0);
        chk("rst_pulses", {parity_err_o, frame_err_o, overflow_o}, 3'b000);
        reset_ni = 1'b1;
        wait_cyc(20);

        // 1: 0x1C, parity 0, with latency of the stop bit
        send_head(8'h1C, 1'b0, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(5);
        chk("t1_valid_early", valid_o, 1'b0);
        wait_cyc(4);
        chk("t1_valid", valid_o, 1'b1);
        chk("t1_data", data_o, 8'h1C);
        chk("t1_count", count_o, 4'd1);
        wait_cyc(HALF - 9);
        ps2_clk = 1'b1;
        wait_cyc(HALF + 5);
        chk("t1_data_hold", data_o, 8'h1C);
        pop_one();
        chk("t1_count_pop", count_o, 4'd0);
        chk("t1_valid_pop", valid_o, 1'b0);
        ready = 1'b1;
        wait_cyc(5);
        ready = 1'b0;
        chk("t1_empty_ready", count_o, 4'd0);

        // 2: bad parity then good parity
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send_frame(8'hAA, 1'b0, 1'b1, 1'b0);
        chk("t2_perr", perr_cnt - p0, 1);
        chk("t2_ferr", ferr_cnt - f0, 0);
        chk("t2_count_bad", count_o, 4'd0);
        send_frame(8'hAA, 1'b1, 1'b1, 1'b0);
        chk("t2_count_good", count_o, 4'd1);
        chk("t2_data_good", data_o, 8'hAA);
        chk("t2_perr_once", perr_cnt - p0, 1);
        pop_one();

        // 3: stop bit 0 then a clean frame
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("t3_ferr", ferr_cnt - f0, 1);
        chk("t3_perr", perr_cnt - p0, 0);
        chk("t3_count", count_o, 4'd0);
        wait_cyc(30);
        send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
        chk("t3_data", data_o, 8'hF0);
        chk("t3_count_good", count_o, 4'd1);
        pop_one();

        // 4: glitches on the PS/2 clock in every phase
        p0 = perr_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        chk("t4_data", data_o, 8'h3C);
        chk("t4_count", count_o, 4'd1);
        wait_cyc(50);
        chk("t4_count_once", count_o, 4'd1);
        chk("t4_errs", (perr_cnt - p0) + (ferr_cnt - f0), 0);
        pop_one();

        // 5: clock stops after five data bits
        f0 = ferr_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(i[0], 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYCLES - 100);
        chk("t5_no_early_tmo", ferr_cnt - f0, 0);
        wait_cyc(200);
        chk("t5_tmo", ferr_cnt - f0, 1);
        chk("t5_count", count_o, 4'd0);
        send_frame(8'h12, 1'b1, 1'b1, 1'b0);
        chk("t5_data", data_o, 8'h12);
        chk("t5_count_good", count_o, 4'd1);
        pop_one();

        // 6: overflow, then push+pop while full, then drain
        o0 = ovf_cnt;
        for (int i = 1; i <= 9; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_frame(b, ~^b, 1'b1, 1'b0);
        end
        chk("t6_count_full", count_o, 4'd8);
        chk("t6_ovf", ovf_cnt - o0, 1);
        chk("t6_head", data_o, 8'h01);
        send_head(8'h0A, 1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(6);
        ready = 1'b1;
        wait_cyc(1);
        ready = 1'b0;
        wait_cyc(2);
        chk("t6_count_pushpop", count_o, 4'd8);
        chk("t6_ovf_pushpop", ovf_cnt - o0, 1);
        chk("t6_head_pushpop", data_o, 8'h02);
        wait_cyc(HALF - 9);
        ps2_clk = 1'b1;
        wait_cyc(HALF);
        for (int i = 2; i <= 8; i++) begin
            chk("t6_drain", data_o, 32'(i));
            pop_one();
        end
        chk("t6_drain_last", data_o, 8'h0A);
        pop_one();
        chk("t6_count_empty", count_o, 4'd0);

        // 7: reset mid-frame with three bytes buffered
        send_frame(8'h21, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        send_frame(8'h23, 1'b0, 1'b1, 1'b0);
        chk("t7_count3", count_o, 4'd3);
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b0, 1'b0);
        p0 = perr_cnt;
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        reset_ni = 1'b0;
        #1;
        chk("t7_valid_rst", valid_o, 1'b0);
        chk("t7_count_rst", count_o, 4'd0);
        chk("t7_data_rst", data_o, 8'h00);
        wait_cyc(3);
        ps2_data = 1'b1;
        reset_ni = 1'b1;
        wait_cyc(20);
        chk("t7_no_pulses", (perr_cnt - p0) + (ferr_cnt - f0) + (ovf_cnt - o0), 0);
        send_frame(8'h77, 1'b1, 1'b1, 1'b0);
        chk("t7_data_fresh", data_o, 8'h77);
        chk("t7_count_fresh", count_o, 4'd1);
        pop_one();
        chk("t7_valid_end", valid_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
